// File: rtl/vlsu_axi_ax_arbiter.sv
// Shares one AXI4 AW/AR master port between NrReq requesters using round-robin grants held until handshake.
// Owner FIFOs keep the issue order so B responses and R bursts return to the requester that issued them.
package vlsu_axi_ax_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  cache;
    } axi_ax_t;
    typedef axi_ax_t axi_aw_t;
    typedef axi_ax_t axi_ar_t;
endpackage

module vlsu_axi_ax_rr #(
    parameter int NrReq = 2,
    parameter int IdxW  = $clog2(NrReq)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NrReq-1:0] req_valid,
    input  logic            full,
    input  logic            down_ready,
    output logic            down_valid,
    output logic [NrReq-1:0] req_ready,
    output logic [IdxW-1:0] grant,
    output logic            push
);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NrReq - 1);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t          state;
    logic [IdxW-1:0] rr_ptr, lock_idx, cand, idx;
    logic            found, any_valid;

    // NOTE: always_comb assigns every output a default first, so no path leaves a latch.
    always_comb begin
        cand  = rr_ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NrReq; k++) begin
            idx = IdxW'((int'(rr_ptr) + k) % NrReq);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                cand  = idx;
            end
        end
    end

    assign grant      = (state == LOCKED) ? lock_idx : cand;
    assign any_valid  = (state == LOCKED) ? req_valid[lock_idx] : |req_valid;
    assign down_valid = any_valid && !full;
    assign push       = down_valid && down_ready;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NrReq; i++)
            req_ready[i] = push && (grant == IdxW'(i));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= UNLOCKED;
            rr_ptr   <= '0;
            lock_idx <= '0;
        end else if (push) begin
            rr_ptr <= (grant == LastIdx) ? '0 : grant + 1'b1;
            state  <= UNLOCKED;
        end else if (state == UNLOCKED && down_valid) begin
            state    <= LOCKED;
            lock_idx <= cand;
        end
    end

    a_locked_valid: assert property (@(posedge clk_i) disable iff (rst_i)
        (state == LOCKED) |-> req_valid[lock_idx])
        else $error("requester dropped valid while locked");
endmodule

module vlsu_axi_ax_own_fifo #(
    parameter int Depth = 8,
    parameter int W     = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push,
    input  logic [W-1:0] data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int PtrW = $clog2(Depth);

    logic [PtrW:0] wr_ptr, rd_ptr;
    logic [W-1:0]  mem [Depth];

    assign full  = (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]) && (wr_ptr[PtrW] != rd_ptr[PtrW]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[PtrW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (push && !full) mem[wr_ptr[PtrW-1:0]] <= data;
    end

    a_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) pop |-> !empty)
        else $error("owner FIFO popped while empty");
endmodule

module vlsu_axi_ax_arbiter #(
    parameter int  NrReq    = 2,
    parameter int  OwnDepth = 8,
    parameter type axi_aw_t = vlsu_axi_ax_pkg::axi_aw_t,
    parameter type axi_ar_t = vlsu_axi_ax_pkg::axi_ar_t
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NrReq-1:0]         req_aw_valid_i,
    output logic [NrReq-1:0]         req_aw_ready_o,
    input  axi_aw_t                  req_aw_i [NrReq],
    input  logic [NrReq-1:0]         req_ar_valid_i,
    output logic [NrReq-1:0]         req_ar_ready_o,
    input  axi_ar_t                  req_ar_i [NrReq],
    output logic [NrReq-1:0]         req_b_valid_o,
    input  logic [NrReq-1:0]         req_b_ready_i,
    output logic                     aw_valid_o,
    input  logic                     aw_ready_i,
    output axi_aw_t                  aw_o,
    output logic                     ar_valid_o,
    input  logic                     ar_ready_i,
    output axi_ar_t                  ar_o,
    input  logic                     b_valid_i,
    output logic                     b_ready_o,
    input  logic                     r_hs_last_i,
    output logic                     r_owner_valid_o,
    output logic [$clog2(NrReq)-1:0] r_owner_o
);
    localparam int IdxW = $clog2(NrReq);

    logic [IdxW-1:0] aw_grant, ar_grant, aw_head, ar_head;
    logic            aw_push, ar_push, aw_full, ar_full, aw_empty, ar_empty, b_pop;

    vlsu_axi_ax_rr #(.NrReq(NrReq), .IdxW(IdxW)) u_aw_rr (
        .clk_i, .rst_i, .req_valid(req_aw_valid_i), .full(aw_full), .down_ready(aw_ready_i),
        .down_valid(aw_valid_o), .req_ready(req_aw_ready_o), .grant(aw_grant), .push(aw_push)
    );

    vlsu_axi_ax_rr #(.NrReq(NrReq), .IdxW(IdxW)) u_ar_rr (
        .clk_i, .rst_i, .req_valid(req_ar_valid_i), .full(ar_full), .down_ready(ar_ready_i),
        .down_valid(ar_valid_o), .req_ready(req_ar_ready_o), .grant(ar_grant), .push(ar_push)
    );

    // Single ID on the master port forces in-order B/R, which is what the owner FIFOs rely on.
    always_comb begin
        aw_o = '0;
        ar_o = '0;
        if (aw_valid_o) begin
            aw_o    = req_aw_i[aw_grant];
            aw_o.id = '0;
        end
        if (ar_valid_o) begin
            ar_o    = req_ar_i[ar_grant];
            ar_o.id = '0;
        end
    end

    vlsu_axi_ax_own_fifo #(.Depth(OwnDepth), .W(IdxW)) u_aw_own (
        .clk_i, .rst_i, .push(aw_push), .data(aw_grant), .pop(b_pop),
        .full(aw_full), .empty(aw_empty), .head(aw_head)
    );

    vlsu_axi_ax_own_fifo #(.Depth(OwnDepth), .W(IdxW)) u_ar_own (
        .clk_i, .rst_i, .push(ar_push), .data(ar_grant), .pop(r_hs_last_i),
        .full(ar_full), .empty(ar_empty), .head(ar_head)
    );

    always_comb begin
        req_b_valid_o = '0;
        if (b_valid_i && !aw_empty) req_b_valid_o[aw_head] = 1'b1;
    end

    assign b_ready_o       = !aw_empty && req_b_ready_i[aw_head];
    assign b_pop           = b_valid_i && b_ready_o;
    assign r_owner_valid_o = !ar_empty;
    assign r_owner_o       = ar_empty ? '0 : ar_head;

    a_b_orphan: assert property (@(posedge clk_i) disable iff (rst_i) b_valid_i |-> !aw_empty)
        else $error("B response with no outstanding AW");
    a_aw_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (aw_valid_o && !aw_ready_i) |=> (!aw_valid_o || $stable(aw_o)))
        else $error("AW payload changed while locked");
    a_ar_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (ar_valid_o && !ar_ready_i) |=> (!ar_valid_o || $stable(ar_o)))
        else $error("AR payload changed while locked");
endmodule

// File: tb/tb_vlsu_axi_ax_arbiter.sv
// Scoreboarded bench for vlsu_axi_ax_arbiter: expected grants are queued at drive time and
// matched at each master handshake; B and R steering are checked against the recorded grant order.
module tb_vlsu_axi_ax_arbiter;
    import vlsu_axi_ax_pkg::*;

    localparam int NrReq    = 2;
    localparam int OwnDepth = 8;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [NrReq-1:0] req_aw_valid_i, req_aw_ready_o, req_ar_valid_i, req_ar_ready_o;
    logic [NrReq-1:0] req_b_valid_o, req_b_ready_i;
    axi_aw_t          req_aw_i [NrReq];
    axi_ar_t          req_ar_i [NrReq];
    logic             aw_valid_o, aw_ready_i, ar_valid_o, ar_ready_i;
    axi_aw_t          aw_o;
    axi_ar_t          ar_o;
    logic             b_valid_i, b_ready_o, r_hs_last_i, r_owner_valid_o;
    logic             r_owner_o;

    typedef struct {
        axi_ax_t pay;
        int      idx;
    } exp_t;

    exp_t aw_q[$];
    exp_t ar_q[$];
    int   b_q[$];
    int   r_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    vlsu_axi_ax_arbiter #(.NrReq(NrReq), .OwnDepth(OwnDepth)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_aw_valid_i(req_aw_valid_i), .req_aw_ready_o(req_aw_ready_o), .req_aw_i(req_aw_i),
        .req_ar_valid_i(req_ar_valid_i), .req_ar_ready_o(req_ar_ready_o), .req_ar_i(req_ar_i),
        .req_b_valid_o(req_b_valid_o), .req_b_ready_i(req_b_ready_i),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_o(aw_o),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_o(ar_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .r_hs_last_i(r_hs_last_i), .r_owner_valid_o(r_owner_valid_o), .r_owner_o(r_owner_o)
    );

    function automatic axi_ax_t mk(int r, int seq);
        axi_ax_t p;
        p.id    = 4'(r + 9);
        p.addr  = 32'h1000 * 32'(r + 1) + 32'(seq * 64);
        p.len   = 8'(seq);
        p.size  = 3'd3;
        p.burst = 2'b01;
        p.cache = 4'h2;
        return p;
    endfunction

    function automatic axi_ax_t strip(axi_ax_t p);
        p.id = '0;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare every master-side handshake against the queued expectation.
    always @(negedge clk) begin : mon
        exp_t             e;
        int               o;
        logic [NrReq-1:0] onehot;
        if (!rst_i) begin
            if (aw_valid_o && aw_ready_i) begin
                n_assert++;
                if (aw_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL aw_hs: unexpected handshake aw_o=%h", aw_o);
                end else begin
                    e = aw_q.pop_front();
                    onehot = '0;
                    onehot[e.idx] = 1'b1;
                    if (aw_o !== e.pay || req_aw_ready_o !== onehot) begin
                        n_fail++;
                        $display("FAIL aw_hs: got aw_o=%h ready=%b, want aw_o=%h ready=%b",
                                 aw_o, req_aw_ready_o, e.pay, onehot);
                    end
                    b_q.push_back(e.idx);
                end
            end
            if (ar_valid_o && ar_ready_i) begin
                n_assert++;
                if (ar_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ar_hs: unexpected handshake ar_o=%h", ar_o);
                end else begin
                    e = ar_q.pop_front();
                    onehot = '0;
                    onehot[e.idx] = 1'b1;
                    if (ar_o !== e.pay || req_ar_ready_o !== onehot) begin
                        n_fail++;
                        $display("FAIL ar_hs: got ar_o=%h ready=%b, want ar_o=%h ready=%b",
                                 ar_o, req_ar_ready_o, e.pay, onehot);
                    end
                    r_q.push_back(e.idx);
                end
            end
            if (b_valid_i && b_ready_o) begin
                n_assert++;
                if (b_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b_hs: unexpected B handshake req_b_valid_o=%b", req_b_valid_o);
                end else begin
                    o = b_q.pop_front();
                    onehot = '0;
                    onehot[o] = 1'b1;
                    if (req_b_valid_o !== onehot) begin
                        n_fail++;
                        $display("FAIL b_hs: got req_b_valid_o=%b, want %b", req_b_valid_o, onehot);
                    end
                end
            end
            if (r_hs_last_i) begin
                n_assert++;
                if (r_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL r_last: no outstanding AR, r_owner_valid_o=%b", r_owner_valid_o);
                end else begin
                    o = r_q.pop_front();
                    if (!r_owner_valid_o || r_owner_o !== 1'(o)) begin
                        n_fail++;
                        $display("FAIL r_last: got owner=%0d valid=%b, want owner=%0d valid=1",
                                 r_owner_o, r_owner_valid_o, o);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_i          = 1'b1;
        req_aw_valid_i = '0;
        req_ar_valid_i = '0;
        req_b_ready_i  = 2'b11;
        aw_ready_i     = 1'b1;
        ar_ready_i     = 1'b1;
        b_valid_i      = 1'b0;
        r_hs_last_i    = 1'b0;
        for (int i = 0; i < NrReq; i++) begin
            req_aw_i[i] = mk(i, 5);
            req_ar_i[i] = mk(i, 6);
        end
        tick();
        tick();
        rst_i = 1'b0;
        #2;
        n_assert++;
        if ({aw_valid_o, ar_valid_o, req_aw_ready_o, req_ar_ready_o, req_b_valid_o, b_ready_o,
             r_owner_valid_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got aw_v=%b ar_v=%b aw_r=%b ar_r=%b b_v=%b b_r=%b r_ov=%b, want all 0",
                     aw_valid_o, ar_valid_o, req_aw_ready_o, req_ar_ready_o, req_b_valid_o,
                     b_ready_o, r_owner_valid_o);
        end
        n_assert++;
        if (aw_o !== '0 || ar_o !== '0) begin
            n_fail++;
            $display("FAIL reset_payload: got aw_o=%h ar_o=%h, want 0", aw_o, ar_o);
        end
        n_assert++;
        if (r_owner_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_owner: got %0d, want 0", r_owner_o);
        end
        tick();
    endtask

    task automatic test_aw_round_robin();
        req_aw_valid_i = 2'b11;
        aw_ready_i     = 1'b1;
        for (int c = 0; c < 4; c++) begin
            req_aw_i[0] = mk(0, c);
            req_aw_i[1] = mk(1, c);
            aw_q.push_back('{pay: strip(req_aw_i[c % 2]), idx: c % 2});
            #2;
            n_assert++;
            if (aw_valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_valid: cycle %0d got aw_valid_o=%b, want 1", c, aw_valid_o);
            end
            tick();
        end
        req_aw_valid_i = '0;
        b_valid_i      = 1'b1;
        req_b_ready_i  = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #2;
            n_assert++;
            if (b_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_b_drain: cycle %0d got b_ready_o=%b, want 1", c, b_ready_o);
            end
            tick();
        end
        b_valid_i = 1'b0;
        #2;
        n_assert++;
        if (b_ready_o !== 1'b0 || b_q.size() != 0) begin
            n_fail++;
            $display("FAIL rr_b_empty: got b_ready_o=%b pending=%0d, want 0 and 0", b_ready_o, b_q.size());
        end
        tick();
    endtask

    task automatic test_lock();
        aw_ready_i     = 1'b0;
        req_aw_valid_i = 2'b10;
        req_aw_i[1]    = mk(1, 20);
        for (int c = 1; c <= 3; c++) begin
            if (c >= 2) req_aw_valid_i = 2'b11;
            req_aw_i[0] = mk(0, 20 + c);
            #2;
            n_assert++;
            if (aw_valid_o !== 1'b1 || aw_o !== strip(mk(1, 20)) || req_aw_ready_o !== 2'b00) begin
                n_fail++;
                $display("FAIL lock_hold: cycle %0d got valid=%b aw_o=%h ready=%b, want 1 %h 00",
                         c, aw_valid_o, aw_o, req_aw_ready_o, strip(mk(1, 20)));
            end
            tick();
        end
        aw_ready_i = 1'b1;
        aw_q.push_back('{pay: strip(mk(1, 20)), idx: 1});
        tick();
        req_aw_i[0] = mk(0, 24);
        aw_q.push_back('{pay: strip(mk(0, 24)), idx: 0});
        #2;
        n_assert++;
        if (aw_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_next: got aw_valid_o=%b, want 1", aw_valid_o);
        end
        tick();
        req_aw_valid_i = '0;
    endtask

    task automatic test_b_steer();
        b_valid_i     = 1'b1;
        req_b_ready_i = 2'b01;
        for (int c = 0; c < 2; c++) begin
            #2;
            n_assert++;
            if (b_ready_o !== 1'b0 || req_b_valid_o !== 2'b10) begin
                n_fail++;
                $display("FAIL b_wait: got b_ready_o=%b req_b_valid_o=%b, want 0 10", b_ready_o, req_b_valid_o);
            end
            tick();
        end
        req_b_ready_i = 2'b10;
        #2;
        n_assert++;
        if (b_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b_owner1: got b_ready_o=%b, want 1", b_ready_o);
        end
        tick();
        req_b_ready_i = 2'b01;
        #2;
        n_assert++;
        if (b_ready_o !== 1'b1 || req_b_valid_o !== 2'b01) begin
            n_fail++;
            $display("FAIL b_owner0: got b_ready_o=%b req_b_valid_o=%b, want 1 01", b_ready_o, req_b_valid_o);
        end
        tick();
        b_valid_i = 1'b0;
    endtask

    task automatic test_full();
        req_aw_valid_i = 2'b01;
        aw_ready_i     = 1'b1;
        for (int c = 0; c < OwnDepth; c++) begin
            req_aw_i[0] = mk(0, 30 + c);
            aw_q.push_back('{pay: strip(req_aw_i[0]), idx: 0});
            #2;
            n_assert++;
            if (aw_valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL full_fill: entry %0d got aw_valid_o=%b, want 1", c, aw_valid_o);
            end
            tick();
        end
        req_aw_i[0] = mk(0, 40);
        for (int c = 0; c < 2; c++) begin
            #2;
            n_assert++;
            if (aw_valid_o !== 1'b0 || req_aw_ready_o !== 2'b00) begin
                n_fail++;
                $display("FAIL full_block: got aw_valid_o=%b ready=%b, want 0 00", aw_valid_o, req_aw_ready_o);
            end
            tick();
        end
        b_valid_i     = 1'b1;
        req_b_ready_i = 2'b01;
        #2;
        n_assert++;
        if (aw_valid_o !== 1'b0 || b_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pop_cycle: got aw_valid_o=%b b_ready_o=%b, want 0 1", aw_valid_o, b_ready_o);
        end
        tick();
        b_valid_i = 1'b0;
        aw_q.push_back('{pay: strip(mk(0, 40)), idx: 0});
        #2;
        n_assert++;
        if (aw_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_resume: got aw_valid_o=%b, want 1", aw_valid_o);
        end
        tick();
        req_aw_valid_i = '0;
        b_valid_i      = 1'b1;
        for (int c = 0; c < OwnDepth; c++) begin
            #2;
            n_assert++;
            if (b_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL full_drain: entry %0d got b_ready_o=%b, want 1", c, b_ready_o);
            end
            tick();
        end
        b_valid_i = 1'b0;
    endtask

    task automatic test_ar_order();
        int owners [3] = '{0, 1, 1};
        ar_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            req_ar_valid_i = (owners[c] == 0) ? 2'b01 : 2'b10;
            req_ar_i[owners[c]] = mk(owners[c], 50 + c);
            ar_q.push_back('{pay: strip(req_ar_i[owners[c]]), idx: owners[c]});
            #2;
            n_assert++;
            if (ar_valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL ar_issue: grant %0d got ar_valid_o=%b, want 1", c, ar_valid_o);
            end
            tick();
        end
        req_ar_valid_i = '0;
        for (int c = 0; c < 3; c++) begin
            r_hs_last_i = 1'b0;
            #2;
            n_assert++;
            if (r_owner_valid_o !== 1'b1 || r_owner_o !== 1'(owners[c])) begin
                n_fail++;
                $display("FAIL r_owner: burst %0d got valid=%b owner=%0d, want 1 %0d",
                         c, r_owner_valid_o, r_owner_o, owners[c]);
            end
            r_hs_last_i = 1'b1;
            tick();
        end
        r_hs_last_i = 1'b0;
        #2;
        n_assert++;
        if (r_owner_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL r_empty: got r_owner_valid_o=%b, want 0", r_owner_valid_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        req_aw_valid_i = 2'b11;
        req_ar_valid_i = 2'b10;
        aw_ready_i     = 1'b1;
        ar_ready_i     = 1'b1;
        req_ar_i[1]    = mk(1, 60);
        ar_q.push_back('{pay: strip(mk(1, 60)), idx: 1});
        // rr pointer sits at req1 after the previous AW grant to req0.
        for (int c = 0; c < 3; c++) begin
            req_aw_i[0] = mk(0, 61 + c);
            req_aw_i[1] = mk(1, 61 + c);
            aw_q.push_back('{pay: strip(req_aw_i[(c + 1) % 2]), idx: (c + 1) % 2});
            tick();
            req_ar_valid_i = '0;
        end
        aw_ready_i     = 1'b0;
        req_aw_valid_i = 2'b10;
        req_aw_i[1]    = mk(1, 70);
        tick();
        req_aw_valid_i = 2'b11;
        #2;
        n_assert++;
        if (aw_valid_o !== 1'b1 || aw_o !== strip(mk(1, 70)) || r_owner_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_lock: got valid=%b aw_o=%h r_ov=%b, want 1 %h 1",
                     aw_valid_o, aw_o, r_owner_valid_o, strip(mk(1, 70)));
        end
        rst_i          = 1'b1;
        req_aw_valid_i = '0;
        aw_q.delete();
        ar_q.delete();
        b_q.delete();
        r_q.delete();
        tick();
        rst_i         = 1'b0;
        req_b_ready_i = 2'b11;
        #2;
        n_assert++;
        if ({aw_valid_o, ar_valid_o, r_owner_valid_o, b_ready_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset: got aw_v=%b ar_v=%b r_ov=%b b_r=%b, want 0000",
                     aw_valid_o, ar_valid_o, r_owner_valid_o, b_ready_o);
        end
        tick();
        req_aw_valid_i = 2'b11;
        aw_ready_i     = 1'b1;
        for (int c = 0; c < OwnDepth; c++) begin
            req_aw_i[0] = mk(0, 80 + c);
            req_aw_i[1] = mk(1, 80 + c);
            aw_q.push_back('{pay: strip(req_aw_i[c % 2]), idx: c % 2});
            #2;
            n_assert++;
            if (aw_valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL mid_refill: entry %0d got aw_valid_o=%b, want 1", c, aw_valid_o);
            end
            tick();
        end
        #2;
        n_assert++;
        if (aw_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_full: got aw_valid_o=%b, want 0", aw_valid_o);
        end
        tick();
        req_aw_valid_i = '0;
    endtask

    initial begin
        test_reset();
        test_aw_round_robin();
        test_lock();
        test_b_steer();
        test_full();
        test_ar_order();
        test_reset_mid();
        tick();
        n_assert++;
        if (aw_q.size() != 0 || ar_q.size() != 0 || r_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got aw=%0d ar=%0d r=%0d pending, want 0 0 0",
                     aw_q.size(), ar_q.size(), r_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
